// File: rtl/logic16_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | logic16_arbiter: shares one 16-bit AND/OR/XOR/NOT unit among NREQ        |
// | requesters with round-robin grant and a tagged valid/ready response.     |
// | Build option: LOGIC16_ARB_FIXED_PRIO_EN selects lowest-index priority.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module logic16_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant;
  logic [IDW-1:0]   g_hi;
  logic [IDW-1:0]   g_any;
  logic [IDW-1:0]   id_q;
  logic             found_hi;
  logic             found_any;
  logic             take;
  logic [1:0]       op_sel;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result;

  // Descending scan: the last hit wins, so g_hi is the lowest valid index at
  // or above rr_ptr and g_any the lowest valid index overall (the wrap case).
  always_comb begin
    found_hi  = 1'b0;
    found_any = 1'b0;
    g_hi      = '0;
    g_any     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        found_any = 1'b1;
        g_any     = IDW'(i);
        if (IDW'(i) >= rr_ptr) begin
          found_hi = 1'b1;
          g_hi     = IDW'(i);
        end
      end
    end
    grant = found_hi ? g_hi : g_any;
  end

  assign take      = (state == IDLE) && !reset && found_any;
  assign req_ready = take ? (NREQ'(1) << grant) : '0;
  assign busy      = (state != IDLE);

  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        op_sel = req_op[2*i +: 2];
        a_sel  = req_a[WIDTH*i +: WIDTH];
        b_sel  = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  always_comb begin
    case (op_q)
      2'b00:   result = a_q & b_q;
      2'b01:   result = a_q | b_q;
      2'b10:   result = a_q ^ b_q;
      default: result = ~a_q;
    endcase
  end

`ifdef LOGIC16_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      id_q      <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
`ifndef LOGIC16_ARB_FIXED_PRIO_EN
      rr_ptr    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found_any) begin
            id_q  <= grant;
            op_q  <= op_sel;
            a_q   <= a_sel;
            b_q   <= b_sel;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= result;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
`ifndef LOGIC16_ARB_FIXED_PRIO_EN
            rr_ptr    <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
`endif
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_logic16_arbiter.sv
`default_nettype none
// Self-checking bench for logic16_arbiter: scoreboard of expected {id, data}
// pushed at grant and popped when the response is offered.
module tb_logic16_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = 4'b1111;
  logic [3:0]  req_ready;
  logic [7:0]  req_op = '0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        busy;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  logic [17:0] exp_q[$];

  logic16_arbiter #(.NREQ(4), .WIDTH(16), .IDW(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] model(input logic [1:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // Waits (bounded) for rsp_valid; samples at negedge+1.
  task automatic wait_rsp(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < 20 && !ok) begin
      @(negedge clk); #1;
      n++;
      if (rsp_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      total++;
      if ({req_ready, rsp_valid, rsp_data, busy} !== 22'h0)
        $display("FAIL reset_state[%0d]: ready=%b valid=%b data=%h busy=%b, expected all zero",
                 k, req_ready, rsp_valid, rsp_data, busy);
      else passed++;
    end
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 4'b0000;
  endtask

  task automatic test_fairness;
    int order[5];
    int n_acc, last, g;
    bit drop;
    logic [17:0] e;
`ifdef LOGIC16_ARB_FIXED_PRIO_EN
    order = '{0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      req_op[2*i +: 2]  = 2'(i);
      req_a[16*i +: 16] = 16'h1357 ^ 16'(16'h1111 * i);
      req_b[16*i +: 16] = 16'hF0F0 >> i;
    end
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    n_acc = 0; last = -1; drop = 1'b0;
    for (int c = 0; c < 60 && (n_acc < 5 || exp_q.size() > 0); c++) begin
      #1;
      if (req_ready != 4'b0000 && n_acc < 5) begin
        g = order[n_acc];
        total++;
        if (req_ready !== (4'b0001 << g))
          $display("FAIL fair_grant[%0d]: req_ready=%b, expected %b", n_acc, req_ready, 4'b0001 << g);
        else passed++;
        if (last >= 0) begin
          total++;
          if (cyc - last != 3)
            $display("FAIL fair_interval[%0d]: got %0d cycles, expected 3", n_acc, cyc - last);
          else passed++;
        end
        last = cyc;
        exp_q.push_back({2'(g), model(req_op[2*g +: 2], req_a[16*g +: 16], req_b[16*g +: 16])});
        n_acc++;
        if (n_acc == 5) drop = 1'b1;
      end
      if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({rsp_id, rsp_data} !== e)
          $display("FAIL fair_rsp: got id=%0d data=%h, expected id=%0d data=%h",
                   rsp_id, rsp_data, e[17:16], e[15:0]);
        else passed++;
      end
      @(negedge clk);
      if (drop) req_valid = 4'b0000;
    end
    total++;
    if (n_acc != 5 || exp_q.size() != 0)
      $display("FAIL fair_done: accepts=%0d pending=%0d, expected 5 and 0", n_acc, exp_q.size());
    else passed++;
    req_valid = 4'b0000;
  endtask

  task automatic test_single;
    int n;
    bit ok;
    logic [17:0] e;
    @(negedge clk);
    req_valid       = 4'b0001;
    req_op[1:0]     = 2'b00;
    req_a[15:0]     = 16'hFFFF;
    req_b[15:0]     = 16'h00FF;
    rsp_ready       = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b, expected 0001", req_ready);
    else passed++;
    exp_q.push_back({2'd0, 16'h00FF});
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    total++;
    if ({rsp_valid, busy} !== 2'b01)
      $display("FAIL single_exec: valid=%b busy=%b, expected 0 1", rsp_valid, busy);
    else passed++;
    wait_rsp(n, ok);
    total++;
    if (!ok || n != 1) $display("FAIL single_latency: got %0d cycles (ok=%0d), expected 1", n, ok);
    else passed++;
    if (ok) begin
      e = exp_q.pop_front();
      total++;
      if ({rsp_id, rsp_data} !== e)
        $display("FAIL single_rsp: got id=%0d data=%h, expected id=%0d data=%h",
                 rsp_id, rsp_data, e[17:16], e[15:0]);
      else passed++;
    end
  endtask

  task automatic test_op_sweep;
    logic [1:0]  ops[4]  = '{2'b01, 2'b10, 2'b00, 2'b11};
    logic [15:0] exps[4] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h5555};
    int n;
    bit ok;
    logic [17:0] e;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_valid     = 4'b0100;
      req_op[5:4]   = ops[k];
      req_a[47:32]  = 16'hAAAA;
      req_b[47:32]  = (ops[k] == 2'b11) ? 16'($urandom) : 16'h5555;
      rsp_ready     = 1'b1;
      #1;
      total++;
      if (req_ready !== 4'b0100) $display("FAIL sweep_ready[%0d]: got %b, expected 0100", k, req_ready);
      else passed++;
      exp_q.push_back({2'd2, exps[k]});
      @(negedge clk);
      req_valid = 4'b0000;
      wait_rsp(n, ok);
      total++;
      if (!ok) begin
        $display("FAIL sweep_timeout[%0d]: rsp_valid=0, expected 1", k);
        void'(exp_q.pop_front());
      end else begin
        e = exp_q.pop_front();
        if ({rsp_id, rsp_data} !== e)
          $display("FAIL sweep_rsp[%0d]: got id=%0d data=%h, expected id=%0d data=%h",
                   k, rsp_id, rsp_data, e[17:16], e[15:0]);
        else passed++;
      end
    end
  endtask

  task automatic test_backpressure;
    int n;
    bit ok;
    logic [17:0] e;
    @(negedge clk);
    req_valid    = 4'b0010;
    req_op[3:2]  = 2'b10;
    req_a[31:16] = 16'h1234;
    req_b[31:16] = 16'hFFFF;
    rsp_ready    = 1'b0;
    #1;
    total++;
    if (req_ready !== 4'b0010) $display("FAIL bp_ready: got %b, expected 0010", req_ready);
    else passed++;
    exp_q.push_back({2'd1, 16'hEDCB});
    @(negedge clk);
    req_valid = 4'b1111;
    wait_rsp(n, ok);
    e = exp_q[0];
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({rsp_valid, rsp_id, rsp_data, req_ready, busy} !== {1'b1, e, 4'b0000, 1'b1})
        $display("FAIL bp_hold[%0d]: valid=%b id=%0d data=%h ready=%b busy=%b, expected 1 %0d %h 0000 1",
                 k, rsp_valid, rsp_id, rsp_data, req_ready, busy, e[17:16], e[15:0]);
      else passed++;
      if (k < 4) begin @(negedge clk); #1; end
    end
    @(negedge clk);
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    #1;
    e = exp_q.pop_front();
    total++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, e})
      $display("FAIL bp_rsp: valid=%b id=%0d data=%h, expected 1 %0d %h",
               rsp_valid, rsp_id, rsp_data, e[17:16], e[15:0]);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({rsp_valid, busy} !== 2'b00)
      $display("FAIL bp_idle: valid=%b busy=%b, expected 0 0", rsp_valid, busy);
    else passed++;
  endtask

  task automatic test_reset_mid_resp;
    int n;
    bit ok;
    logic [17:0] e;
    // Complete one grant to requester 0 so the pointer moves off zero.
    @(negedge clk);
    req_valid   = 4'b0001;
    req_op[1:0] = 2'b00;
    req_a[15:0] = 16'hF0F0;
    req_b[15:0] = 16'hFF00;
    rsp_ready   = 1'b1;
    #1;
    exp_q.push_back({2'd0, 16'hF000});
    @(negedge clk);
    req_valid = 4'b0000;
    wait_rsp(n, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || {rsp_id, rsp_data} !== e)
      $display("FAIL pre_rsp: ok=%0d id=%0d data=%h, expected id=%0d data=%h",
               ok, rsp_id, rsp_data, e[17:16], e[15:0]);
    else passed++;
    @(negedge clk);
    req_valid     = 4'b1000;
    req_op[7:6]   = 2'b01;
    req_a[63:48]  = 16'h0F00;
    req_b[63:48]  = 16'h00F0;
    rsp_ready     = 1'b0;
    #1;
    total++;
    if (req_ready !== 4'b1000) $display("FAIL abort_ready: got %b, expected 1000", req_ready);
    else passed++;
    exp_q.push_back({2'd3, 16'h0FF0});
    @(negedge clk);
    req_valid = 4'b0000;
    wait_rsp(n, ok);
    total++;
    if (!ok) $display("FAIL abort_valid: rsp_valid=0, expected 1 before reset");
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    total++;
    if ({rsp_valid, busy, req_ready} !== 6'b0)
      $display("FAIL abort_cleared: valid=%b busy=%b ready=%b, expected 0 0 0000",
               rsp_valid, busy, req_ready);
    else passed++;
    exp_q.delete();
    @(negedge clk);
    reset       = 1'b0;
    req_valid   = 4'b0011;
    req_op[3:2] = 2'b11;
    rsp_ready   = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0001) $display("FAIL post_reset_grant: got %b, expected 0001", req_ready);
    else passed++;
    exp_q.push_back({2'd0, model(req_op[1:0], req_a[15:0], req_b[15:0])});
    @(negedge clk);
    req_valid = 4'b0000;
    wait_rsp(n, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || {rsp_id, rsp_data} !== e)
      $display("FAIL post_reset_rsp: ok=%0d id=%0d data=%h, expected id=%0d data=%h",
               ok, rsp_id, rsp_data, e[17:16], e[15:0]);
    else passed++;
    total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_empty: %0d pending, expected 0", exp_q.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_op_sweep();
    test_backpressure();
    test_reset_mid_resp();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
    $fatal(1);
  end

endmodule
`default_nettype wire
